// File: rtl/button_stepper.sv
// Front-panel button stepper: turns a debounced button level into press,
// release and CPU step pulses, with hold-to-auto-repeat and a step counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | button not accepted, waiting for a rising edge
// ST_HOLD   | accepted press, counting towards the first repeat step
// ST_REPEAT | auto-repeat active, step every REPEAT_COUNT cycles
module button_stepper #(
  parameter int CNT_WIDTH    = 25,
  parameter int HOLD_COUNT   = 25_000_000,
  parameter int REPEAT_COUNT = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_clean,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       step_pulse,
  output logic       repeating,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 btn_q;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 step_q, step_d;
  logic                 rep_q, rep_d;
  logic [7:0]           step_cnt_q, step_cnt_d;

  logic rise;
  logic fall;

  // btn_q resets high so a button held through reset must be released first.
  assign rise = btn_clean & ~btn_q;
  assign fall = ~btn_clean;

  // Next-state, counter and pulse decode; fall always wins over an expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          step_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          if (repeat_en) begin
            step_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = HOLD_LAST;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (!repeat_en) begin
          // Park saturated in HOLD so re-enabling repeat steps immediately.
          cnt_d   = HOLD_LAST;
          state_d = ST_HOLD;
        end else if (cnt_q == REPEAT_LAST) begin
          step_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    rep_d      = (state_d == ST_REPEAT);
    step_cnt_d = step_cnt_q + 8'(step_d);
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      btn_q      <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      step_q     <= 1'b0;
      rep_q      <= 1'b0;
      step_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn_clean;
      press_q    <= press_d;
      release_q  <= release_d;
      step_q     <= step_d;
      rep_q      <= rep_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;
  assign repeating     = rep_q;
  assign step_count    = step_cnt_q;

endmodule

// File: tb/tb_button_stepper.sv
// Bench for button_stepper: an elapsed-time model of press/step/repeat
// behaviour checked every cycle, plus directed scenarios with literal
// expectations on pulse timing and counts.
module tb_button_stepper;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_clean;
  logic       repeat_en;
  logic       press_pulse;
  logic       release_pulse;
  logic       step_pulse;
  logic       repeating;
  logic [7:0] step_count;

  button_stepper #(
    .CNT_WIDTH   (25),
    .HOLD_COUNT  (HOLD),
    .REPEAT_COUNT(REP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_clean    (btn_clean),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse),
    .repeating    (repeating),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model: time elapsed since the last step, and the period now in force
  bit       m_active  = 1'b0;
  bit       m_prev    = 1'b1;
  bit       m_rep     = 1'b0;
  int       m_elapsed = 0;
  int       m_period  = HOLD;
  bit       m_press   = 1'b0;
  bit       m_release = 1'b0;
  bit       m_step    = 1'b0;
  bit [7:0] m_cnt     = 8'd0;

  // event log, offsets relative to the most recent press pulse
  int step_q[$];
  int press_n     = 0;
  int release_n   = 0;
  int release_off = -1;
  int rep_first   = -1;
  int press_cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got [%s], expected [%s]", name, act, exp);
    end
  endtask

  function automatic string steps_str();
    string s = "";
    foreach (step_q[i]) s = {s, $sformatf("%0d,", step_q[i])};
    return s;
  endfunction

  // Behavioural model advanced on each sampling edge.
  always @(posedge clk) begin
    cyc++;
    m_press   = 1'b0;
    m_release = 1'b0;
    m_step    = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_prev   = 1'b1;
      m_rep    = 1'b0;
      m_cnt    = 8'd0;
    end else begin
      if (!m_active) begin
        if (btn_clean && !m_prev) begin
          m_press   = 1'b1;
          m_step    = 1'b1;
          m_active  = 1'b1;
          m_elapsed = 0;
          m_period  = HOLD;
          m_rep     = 1'b0;
        end
      end else begin
        m_elapsed++;
        if (!btn_clean) begin
          m_release = 1'b1;
          m_active  = 1'b0;
          m_rep     = 1'b0;
        end else if (m_rep && !repeat_en) begin
          m_rep     = 1'b0;
          m_period  = HOLD;
          m_elapsed = HOLD;
        end else if (repeat_en && m_elapsed >= m_period) begin
          m_step    = 1'b1;
          m_elapsed = 0;
          m_period  = REP;
          m_rep     = 1'b1;
        end
      end
      m_prev = btn_clean;
      if (m_step) m_cnt = m_cnt + 8'd1;
    end
  end

  // Per-cycle compare against the model, then event logging.
  always @(negedge clk) begin
    check("press_pulse", int'(press_pulse), int'(m_press));
    check("release_pulse", int'(release_pulse), int'(m_release));
    check("step_pulse", int'(step_pulse), int'(m_step));
    check("repeating", int'(repeating), int'(m_rep));
    check("step_count", int'(step_count), int'(m_cnt));
    if (press_pulse === 1'b1) begin
      press_n++;
      press_cyc = cyc;
    end
    if (step_pulse === 1'b1) step_q.push_back(cyc - press_cyc);
    if (release_pulse === 1'b1) begin
      release_n++;
      release_off = cyc - press_cyc;
    end
    if (repeating === 1'b1 && rep_first < 0) rep_first = cyc - press_cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    step_q.delete();
    press_n     = 0;
    release_n   = 0;
    release_off = -1;
    rep_first   = -1;
    press_cyc   = cyc;
  endtask

  task automatic do_reset();
    btn_clean = 1'b0;
    repeat_en = 1'b0;
    rst_n     = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_log();
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_clean = 1'b0;
    repeat_en = 1'b0;
    tick(3);
    check("reset press", int'(press_pulse), 0);
    check("reset release", int'(release_pulse), 0);
    check("reset step", int'(step_pulse), 0);
    check("reset repeating", int'(repeating), 0);
    check("reset count", int'(step_count), 0);
    rst_n = 1'b1;
    tick(2);
    clear_log();

    // single tap
    btn_clean = 1'b1;
    tick(3);
    btn_clean = 1'b0;
    tick(5);
    check("tap presses", press_n, 1);
    check_str("tap steps", steps_str(), "0,");
    check("tap release offset", release_off, 3);
    check("tap releases", release_n, 1);
    check("tap count", int'(step_count), 1);
    check("tap repeating seen", rep_first, -1);

    // hold with repeat for 20 cycles
    do_reset();
    repeat_en = 1'b1;
    btn_clean = 1'b1;
    tick(21);
    btn_clean = 1'b0;
    tick(4);
    check_str("repeat steps", steps_str(), "0,8,12,16,20,");
    check("repeat first repeating", rep_first, 8);
    check("repeat count", int'(step_count), 5);
    check("repeat release offset", release_off, 21);

    // hold with repeat disabled, then enable
    do_reset();
    btn_clean = 1'b1;
    tick(15);
    check_str("norepeat steps", steps_str(), "0,");
    check("norepeat count", int'(step_count), 1);
    repeat_en = 1'b1;
    tick(9);
    check_str("late enable steps", steps_str(), "0,15,19,23,");
    btn_clean = 1'b0;
    tick(3);
    check("late enable count", int'(step_count), 4);

    // repeat_en dropped mid-repeat, then restored
    do_reset();
    repeat_en = 1'b1;
    btn_clean = 1'b1;
    tick(14);
    repeat_en = 1'b0;
    tick(2);
    check("drop repeating", int'(repeating), 0);
    repeat_en = 1'b1;
    tick(3);
    btn_clean = 1'b0;
    tick(3);
    check_str("drop steps", steps_str(), "0,8,12,16,");

    // release exactly on the hold expiry edge
    do_reset();
    repeat_en = 1'b1;
    btn_clean = 1'b1;
    tick(8);
    btn_clean = 1'b0;
    tick(4);
    check("expiry release offset", release_off, 8);
    check_str("expiry steps", steps_str(), "0,");
    check("expiry count", int'(step_count), 1);

    // reset mid-repeat with the button held
    do_reset();
    repeat_en = 1'b1;
    btn_clean = 1'b1;
    tick(14);
    check("pre-reset repeating", int'(repeating), 1);
    rst_n = 1'b0;
    clear_log();
    tick(2);
    check("mid reset step", int'(step_pulse), 0);
    check("mid reset repeating", int'(repeating), 0);
    check("mid reset count", int'(step_count), 0);
    rst_n = 1'b1;
    tick(5);
    check("held through reset presses", press_n, 0);
    check("held through reset releases", release_n, 0);
    btn_clean = 1'b0;
    tick(1);
    btn_clean = 1'b1;
    tick(2);
    check("repress after 1-cycle low", press_n, 1);
    btn_clean = 1'b0;
    tick(2);

    // 256 taps wrap the step counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      btn_clean = 1'b1;
      tick(1);
      btn_clean = 1'b0;
      tick(1);
    end
    tick(2);
    check("wrap presses", press_n, 256);
    check("wrap steps", step_q.size(), 256);
    check("wrap count", int'(step_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
